mult_iter_dp: RTL

Parametrised iterative mantissa multiplier datapath for the FPU. It is the successor to the fixed SP/DP carry-save multiplier datapath.
- Retires R multiplier bits per cycle into a carry-save accumulator, then performs one final carry-propagate add.
- Normalises the result and rounds it in one of three modes.
- Replaces the hard-wired mux-control sequencing with an internal start/done FSM.
- Honours fpuhold as a global freeze.

---
 rtl/mult_iter_dp.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mult_iter_dp.sv
// Iterative unsigned mantissa multiplier: R multiplier bits per cycle into a
// carry-save accumulator, one final CPA, then normalise and round (RNE/RTZ/RU).

module mult_pp_row #(
    parameter int PW = 49,
    parameter int SH = 0
) (
    input  logic [PW-1:0] mc,
    input  logic          sel,
    output logic [PW-1:0] pp
);
    assign pp = sel ? (mc << SH) : '0;
endmodule

module mult_iter_dp #(
    parameter int W = 24,
    parameter int R = 8
) (
    input  logic           clk,
    input  logic           reset_l,
    input  logic           fpuhold,
    input  logic           flush,
    input  logic           start,
    input  logic [W-1:0]   mcand,
    input  logic [W-1:0]   mplier,
    input  logic [1:0]     rnd_mode,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   mant,
    output logic [2*W-1:0] prod,
    output logic           movf,
    output logic           inexact,
    output logic           rnd_ovf
);
    localparam int ITER = (W + R - 1) / R;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int PW   = 2 * W + 1;

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_FIN} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [PW-1:0] mc_sh;
    logic [W-1:0]  mpl_sh;
    logic [1:0]    rm_q;
    logic [PW-1:0] sum_q, carry_q;

    assign busy = (state != S_IDLE);

    // mc_sh/mpl_sh step by R each ACC cycle, so row j always sees bit cnt*R+j
    // at weight cnt*R+j; bits past W shift in as zero.
    logic [R-1:0][PW-1:0] pp;
    for (genvar j = 0; j < R; j++) begin : g_row
        mult_pp_row #(.PW(PW), .SH(j)) u_row (
            .mc  (mc_sh),
            .sel (mpl_sh[j]),
            .pp  (pp[j])
        );
    end

    logic [PW-1:0] cs_s, cs_c, cs_t;
    always_comb begin
        cs_s = sum_q;
        cs_c = carry_q;
        cs_t = '0;
        for (int j = 0; j < R; j++) begin
            cs_t = cs_s ^ cs_c ^ pp[j];
            cs_c = ((cs_s & cs_c) | (cs_s & pp[j]) | (cs_c & pp[j])) << 1;
            cs_s = cs_t;
        end
    end

    // Product always fits in 2W bits; the extra carry-save bit is dropped here.
    logic [2*W-1:0] p;
    assign p = (2*W)'(sum_q + carry_q);

    logic [W-1:0] m;
    logic         g, s, inc;
    logic [W:0]   m_inc;
    always_comb begin
        if (p[2*W-1]) begin
            m = p[2*W-1:W];
            g = p[W-1];
            s = |p[W-2:0];
        end else begin
            m = p[2*W-2:W-1];
            g = p[W-2];
            s = |p[W-3:0];
        end
        case (rm_q)
            2'b00:   inc = g & (s | m[0]);
            2'b10:   inc = g | s;
            default: inc = 1'b0;
        endcase
        m_inc = {1'b0, m} + (W+1)'(inc);
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state   <= S_IDLE;
            cnt     <= '0;
            mc_sh   <= '0;
            mpl_sh  <= '0;
            rm_q    <= '0;
            sum_q   <= '0;
            carry_q <= '0;
            done    <= 1'b0;
            mant    <= '0;
            prod    <= '0;
            movf    <= 1'b0;
            inexact <= 1'b0;
            rnd_ovf <= 1'b0;
        end else if (flush) begin
            state <= S_IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else if (!fpuhold) begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    mc_sh   <= PW'(mcand);
                    mpl_sh  <= mplier;
                    rm_q    <= rnd_mode;
                    sum_q   <= '0;
                    carry_q <= '0;
                    cnt     <= '0;
                    state   <= S_ACC;
                end
                S_ACC: begin
                    sum_q   <= cs_s;
                    carry_q <= cs_c;
                    mc_sh   <= mc_sh << R;
                    mpl_sh  <= mpl_sh >> R;
                    cnt     <= cnt + 1'b1;
                    if (cnt == CW'(ITER - 1)) state <= S_FIN;
                end
                S_FIN: begin
                    prod    <= p;
                    movf    <= p[2*W-1];
                    inexact <= g | s;
                    rnd_ovf <= m_inc[W];
                    mant    <= m_inc[W] ? (W'(1) << (W - 1)) : m_inc[W-1:0];
                    done    <= 1'b1;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
